// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the load/store path. It turns core load/store controls into word-aligned
// transactions with byte enables, and runs each access through a req/ack
// handshake with variable latency. The core is stalled until the access
// completes. Data accesses have fixed priority over fetches.
// Optional feature macro: MEM_ARB_MISALIGN_CHECK_EN. When it is defined,
// misaligned HALF/WORD data accesses complete with dmem_err and no memory cycle.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_dmem_req,
    input  logic              i_dmem_wr,
    input  logic [1:0]        i_dmem_size,
    input  logic              i_dmem_zero_ex,
    input  logic [ADDR_W-1:0] i_dmem_addr,
    input  logic [DATA_W-1:0] i_dmem_wdata,
    output logic [DATA_W-1:0] o_dmem_rdata,
    output logic              o_dmem_done,
    output logic              o_dmem_err,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [1:0] OP_DMEM_BYTE = 2'b00;
    localparam logic [1:0] OP_DMEM_HALF = 2'b01;
    localparam logic [1:0] OP_DMEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUSY = 2'd1,
        S_D_BUSY  = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_take_if;
    logic w_take_data;
    logic w_misalign;
    logic w_if_ack;
    logic w_d_ack;
    logic w_req_misaligned;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dmem_done;
    logic              r_dmem_err;
    logic [DATA_W-1:0] r_dmem_rdata;
    logic              r_d_wr;
    logic [1:0]        r_d_size;
    logic              r_d_zero_ex;
    logic [1:0]        r_d_off;

    // Fetch words are always aligned, so the low fetch address bits are dropped.
    logic w_unused_if_lsb;
    assign w_unused_if_lsb = ^i_if_addr[1:0];

    // Byte enables for a store; sizes outside BYTE/HALF act as WORD.
    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            OP_DMEM_BYTE: be = 4'b0001 << off;
            OP_DMEM_HALF: be = 4'b0011 << {off[1], 1'b0};
            default:      be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so that the enabled lanes carry it.
    function automatic logic [DATA_W-1:0] f_wdata(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] res;
        case (size)
            OP_DMEM_BYTE: res = {4{wd[7:0]}};
            OP_DMEM_HALF: res = {2{wd[15:0]}};
            default:      res = wd;
        endcase
        return res;
    endfunction

    // Shift the addressed lane(s) down, truncate, then sign- or zero-extend.
    function automatic logic [DATA_W-1:0] f_load(input logic [1:0] size,
                                                 input logic zx,
                                                 input logic [1:0] off,
                                                 input logic [DATA_W-1:0] rd);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh  = rd;
        res = rd;
        case (size)
            OP_DMEM_BYTE: begin
                sh  = rd >> {off, 3'b000};
                res = zx ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            OP_DMEM_HALF: begin
                sh  = rd >> {off[1], 4'b0000};
                res = zx ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: res = rd;
        endcase
        return res;
    endfunction

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    // HALF needs an even address, WORD needs a multiple of four.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            OP_DMEM_BYTE: bad = 1'b0;
            OP_DMEM_HALF: bad = off[0];
            default:      bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    assign w_req_misaligned = f_misaligned(i_dmem_size, i_dmem_addr[1:0]);
`else
    assign w_req_misaligned = 1'b0;
`endif

    // Next-state and per-cycle event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_take_if   = 1'b0;
        w_take_data = 1'b0;
        w_misalign  = 1'b0;
        w_if_ack    = 1'b0;
        w_d_ack     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_dmem_req) begin
                    w_take_data = 1'b1;
                    if (w_req_misaligned) begin
                        w_misalign  = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_D_BUSY;
                    end
                end else if (i_if_req) begin
                    w_take_if   = 1'b1;
                    w_state_nxt = S_IF_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IF_BUSY: begin
                if (i_mem_ack) begin
                    w_if_ack    = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_IF_BUSY;
                end
            end
            S_D_BUSY: begin
                if (i_mem_ack) begin
                    w_d_ack     = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_D_BUSY;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-side request fields, latched when a request is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            r_mem_req <= (w_state_nxt == S_IF_BUSY) || (w_state_nxt == S_D_BUSY);
            if (w_take_if) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {i_if_addr[ADDR_W-1:2], 2'b00};
                r_mem_be    <= 4'b1111;
                r_mem_wdata <= {DATA_W{1'b0}};
            end else if (w_take_data && !w_misalign) begin
                r_mem_we    <= i_dmem_wr;
                r_mem_addr  <= {i_dmem_addr[ADDR_W-1:2], 2'b00};
                r_mem_be    <= i_dmem_wr ? f_be(i_dmem_size, i_dmem_addr[1:0]) : 4'b1111;
                r_mem_wdata <= i_dmem_wr ? f_wdata(i_dmem_size, i_dmem_wdata) : {DATA_W{1'b0}};
            end
        end
    end

    // Data command fields kept for formatting the load result at ack time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_wr      <= 1'b0;
            r_d_size    <= 2'b00;
            r_d_zero_ex <= 1'b0;
            r_d_off     <= 2'b00;
        end else if (w_take_data) begin
            r_d_wr      <= i_dmem_wr;
            r_d_size    <= i_dmem_size;
            r_d_zero_ex <= i_dmem_zero_ex;
            r_d_off     <= i_dmem_addr[1:0];
        end
    end

    // Completion pulses and captured results, presented during RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_if_valid   <= 1'b0;
            r_if_rdata   <= {DATA_W{1'b0}};
            r_dmem_done  <= 1'b0;
            r_dmem_err   <= 1'b0;
            r_dmem_rdata <= {DATA_W{1'b0}};
        end else begin
            r_if_valid  <= w_if_ack;
            r_dmem_done <= w_d_ack | w_misalign;
            r_dmem_err  <= w_misalign;
            if (w_if_ack) begin
                r_if_rdata <= i_mem_rdata;
            end
            if (w_d_ack) begin
                r_dmem_rdata <= r_d_wr ? {DATA_W{1'b0}}
                                       : f_load(r_d_size, r_d_zero_ex, r_d_off, i_mem_rdata);
            end else if (w_misalign) begin
                r_dmem_rdata <= {DATA_W{1'b0}};
            end
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_be     = r_mem_be;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_if_valid   = r_if_valid;
    assign o_if_rdata   = r_if_rdata;
    assign o_dmem_done  = r_dmem_done;
    assign o_dmem_err   = r_dmem_err;
    assign o_dmem_rdata = r_dmem_rdata;

    // The core is held while it has an outstanding request that has not completed.
    assign o_stall = (i_if_req & ~r_if_valid) | (i_dmem_req & ~r_dmem_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table vectors, hand-written
// multi-cycle sequences and randomized traffic against a byte-lane model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dmem_req;
    logic        dmem_wr;
    logic [1:0]  dmem_size;
    logic        dmem_zero_ex;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_done;
    logic        dmem_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_valid(if_valid),
        .i_dmem_req(dmem_req), .i_dmem_wr(dmem_wr), .i_dmem_size(dmem_size),
        .i_dmem_zero_ex(dmem_zero_ex), .i_dmem_addr(dmem_addr), .i_dmem_wdata(dmem_wdata),
        .o_dmem_rdata(dmem_rdata), .o_dmem_done(dmem_done), .o_dmem_err(dmem_err),
        .o_stall(stall), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-lane view) ----------------
    function automatic int m_nbytes(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int m_start(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return int'(addr[1:0]);
        if (size == 2'd1) return addr[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int st = m_start(size, addr);
        int n  = m_nbytes(size);
        for (int i = 0; i < 4; i++) be[i] = (i >= st) && (i < st + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int n = m_nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic zx,
                                           input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] r = 32'h0;
        int st = m_start(size, addr);
        int n  = m_nbytes(size);
        for (int k = 0; k < n; k++) r[8*k +: 8] = rd[8*(st+k) +: 8];
        if (n < 4 && !zx && r[8*n-1]) begin
            for (int k = n; k < 4; k++) r[8*k +: 8] = 8'hFF;
        end
        return r;
    endfunction

    // ---------------- transaction drivers ----------------
    task automatic do_data(input logic wr, input logic [1:0] size, input logic zx,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        dmem_req = 1'b1; dmem_wr = wr; dmem_size = size; dmem_zero_ex = zx;
        dmem_addr = addr; dmem_wdata = wd;
        @(negedge clk);
        chk("d_mem_req", {31'd0, mem_req}, 32'd1);
        chk("d_mem_we", {31'd0, mem_we}, {31'd0, wr});
        chk("d_mem_addr", mem_addr, e_addr);
        chk("d_mem_be", {28'd0, mem_be}, {28'd0, e_be});
        if (wr) chk("d_mem_wdata", mem_wdata, e_wdata);
        chk("d_stall_busy", {31'd0, stall}, 32'd1);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("d_wait_req", {31'd0, mem_req}, 32'd1);
            chk("d_wait_done", {31'd0, dmem_done}, 32'd0);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk("d_done", {31'd0, dmem_done}, 32'd1);
        chk("d_err", {31'd0, dmem_err}, 32'd0);
        if (!wr) chk("d_rdata", dmem_rdata, e_rdata);
        chk("d_resp_req", {31'd0, mem_req}, 32'd0);
        chk("d_resp_stall", {31'd0, stall}, 32'd0);
        dmem_req = 1'b0;
        @(negedge clk);
        chk("d_done_pulse", {31'd0, dmem_done}, 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rd, input int lat);
        if_req = 1'b1; if_addr = addr;
        @(negedge clk);
        chk("f_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("f_mem_be", {28'd0, mem_be}, 32'hF);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("f_wait_valid", {31'd0, if_valid}, 32'd0);
            chk("f_wait_stall", {31'd0, stall}, 32'd1);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk("f_valid", {31'd0, if_valid}, 32'd1);
        chk("f_rdata", if_rdata, rd);
        chk("f_resp_stall", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("f_valid_pulse", {31'd0, if_valid}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        zx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        wr;
        logic        zx;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  ebe;

        //               wr    size   zx    addr          wdata         rdata         e_addr        e_be     e_wdata       e_rdata
        vecs[0] = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00AB, 32'h0,        32'h0000_0200, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1] = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_1234, 32'h0,        32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0};
        vecs[2] = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1'b0, 2'd0, 1'b0, 32'h0000_0202, 32'h0,         32'h80F0_7F01, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF_FFF0};
        vecs[4] = '{1'b0, 2'd0, 1'b1, 32'h0000_0202, 32'h0,         32'h80F0_7F01, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_00F0};
        vecs[5] = '{1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,         32'h80F0_7F01, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF_80F0};
        vecs[6] = '{1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0,         32'h80F0_7F01, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_7F01};
        vecs[7] = '{1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0,         32'h80F0_7F01, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_007F};
        vecs[8] = '{1'b0, 2'd3, 1'b0, 32'h0000_0204, 32'h0,         32'h80F0_7F01, 32'h0000_0204, 4'b1111, 32'h0,        32'h80F0_7F01};

        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dmem_req = 1'b0; dmem_wr = 1'b0;
        dmem_size = 2'd0; dmem_zero_ex = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_done", {31'd0, dmem_done}, 32'd0);
        chk("rst_err", {31'd0, dmem_err}, 32'd0);
        chk("rst_rdata", dmem_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // fetch with ack three cycles after the request appears
        do_fetch(32'h0000_0104, 32'h0050_0093, 3);
        do_fetch(32'h0000_0107, 32'h1357_9BDF, 1);

        // table-driven data vectors
        for (int i = 0; i < 9; i++) begin
            do_data(vecs[i].wr, vecs[i].size, vecs[i].zx, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, 1 + (i % 3), vecs[i].e_addr, vecs[i].e_be,
                    vecs[i].e_wdata, vecs[i].e_rdata);
        end

        // contention: data first, fetch after the data RESP
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = 2'd2; dmem_zero_ex = 1'b0;
        dmem_addr = 32'h0000_0300; if_req = 1'b1; if_addr = 32'h0000_0400;
        @(negedge clk);
        chk("c_first_addr", mem_addr, 32'h0000_0300);
        chk("c_first_req", {31'd0, mem_req}, 32'd1);
        chk("c_stall1", {31'd0, stall}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("c_done", {31'd0, dmem_done}, 32'd1);
        chk("c_rdata", dmem_rdata, 32'h1122_3344);
        chk("c_no_ifvalid", {31'd0, if_valid}, 32'd0);
        chk("c_stall2", {31'd0, stall}, 32'd1);
        dmem_req = 1'b0;
        @(negedge clk);
        chk("c_idle_req", {31'd0, mem_req}, 32'd0);
        chk("c_stall3", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("c_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("c_fetch_addr", mem_addr, 32'h0000_0400);
        mem_ack = 1'b1; mem_rdata = 32'h5566_7788;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("c_if_valid", {31'd0, if_valid}, 32'd1);
        chk("c_if_rdata", if_rdata, 32'h5566_7788);
        chk("c_stall4", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);

        // reset while D_BUSY, then a late ack
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = 2'd2; dmem_addr = 32'h0000_0500;
        @(negedge clk);
        chk("r_busy_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; dmem_req = 1'b0;
        @(negedge clk);
        chk("r_req_dropped", {31'd0, mem_req}, 32'd0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("r_no_done", {31'd0, dmem_done}, 32'd0);
        chk("r_idle_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("r_no_done2", {31'd0, dmem_done}, 32'd0);
        do_fetch(32'h0000_0600, 32'h0BAD_CAFE, 2);

`ifdef MEM_ARB_MISALIGN_CHECK_EN
        // misaligned LW: no memory cycle, done+err one cycle after sampling
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = 2'd2; dmem_addr = 32'h0000_0202;
        @(negedge clk);
        chk("m_done", {31'd0, dmem_done}, 32'd1);
        chk("m_err", {31'd0, dmem_err}, 32'd1);
        chk("m_rdata", dmem_rdata, 32'd0);
        chk("m_no_req", {31'd0, mem_req}, 32'd0);
        dmem_req = 1'b0;
        @(negedge clk);
        chk("m_done_pulse", {31'd0, dmem_done}, 32'd0);
        chk("m_err_pulse", {31'd0, dmem_err}, 32'd0);
        chk("m_no_req2", {31'd0, mem_req}, 32'd0);
`else
        // without the check, misaligned WORD ignores addr[1:0] and HALF uses addr[1]
        do_data(1'b0, 2'd2, 1'b0, 32'h0000_0202, 32'h0, 32'h80F0_7F01, 2,
                32'h0000_0200, 4'b1111, 32'h0, 32'h80F0_7F01);
        do_data(1'b0, 2'd1, 1'b0, 32'h0000_0203, 32'h0, 32'h80F0_7F01, 1,
                32'h0000_0200, 4'b1111, 32'h0, 32'hFFFF_80F0);
        do_data(1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'h0000_BEEF, 32'h0, 1,
                32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 32'h0);
`endif

        // randomized traffic against the byte-lane model
        for (int it = 0; it < 60; it++) begin
            a  = $urandom;
            rd = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                do_fetch(a, rd, $urandom_range(1, 4));
            end else begin
                wr = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                zx = 1'($urandom_range(0, 1));
                wd = $urandom;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
`endif
                ebe = wr ? m_be(sz, a) : 4'b1111;
                do_data(wr, sz, zx, a, wd, rd, $urandom_range(1, 4), {a[31:2], 2'b00},
                        ebe, m_wdata(sz, wd), m_load(sz, zx, a, rd));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between instruction fetch and the data-access path of the RISC-V core. Translates the core's load/store controls (dmem_req, dmem_wr, dmem_size, dmem_zero_ex) into word-aligned memory transactions with byte enables. Sequences each access through a request/acknowledge handshake with variable memory latency, and stalls the core until the access completes. Sits between the core datapath and the memory model/bus.

## Interface
- ADDR_W, 32, address width of the core and memory.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held stable until if_valid.
- if_addr  in  ADDR_W  fetch address; bits [1:0] ignored.
- if_rdata  out  DATA_W  fetched word; valid while if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- dmem_req  in  1  data request; held stable until dmem_done.
- dmem_wr  in  1  1 = store, 0 = load.
- dmem_size  in  2  op_dmem_size: OP_DMEM_BYTE / OP_DMEM_HALF / OP_DMEM_WORD.
- dmem_zero_ex  in  1  1 = zero-extend a load, 0 = sign-extend.
- dmem_addr  in  ADDR_W  byte address.
- dmem_wdata  in  DATA_W  store data, right-aligned.
- dmem_rdata  out  DATA_W  aligned and extended load data; valid while dmem_done.
- dmem_done  out  1  one-cycle data completion pulse (loads and stores).
- dmem_err  out  1  misaligned access; qualified by dmem_done.
- stall  out  1  (if_req & ~if_valid) | (dmem_req & ~dmem_done); combinational.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- mem_be  out  4  byte enables (writes); 4'b1111 for reads.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  read word.

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE: if dmem_req, latch data command and go to D_BUSY. Else if if_req, latch fetch and go to IF_BUSY. Data has fixed priority over fetch.
- IF_BUSY/D_BUSY: mem_req=1 with latched fields. On mem_ack, capture mem_rdata, drive result, and go to RESP.
- RESP: pulse if_valid or dmem_done (exactly one) with registered result. Return to IDLE; no request is sampled in RESP.
- Byte enables:
  - BYTE: 4'b0001 << addr[1:0].
  - HALF: 4'b0011 << {addr[1],1'b0}.
  - WORD: 4'b1111.
- Write data:
  - BYTE: {4{wdata[7:0]}}.
  - HALF: {2{wdata[15:0]}}.
  - WORD: wdata.
- Load data: mem_rdata >> (8*addr[1:0]), then truncate to size. Extend from bit 7 or bit 15, with zeros if dmem_zero_ex. WORD loads are unextended.
- dmem_size encoding 2'b11 is treated as WORD.
- mem_ack outside IF_BUSY/D_BUSY is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - mem_req, mem_we, if_valid, dmem_done and dmem_err are 0.
  - mem_be is 4'b0000.
  - mem_addr, mem_wdata, if_rdata and dmem_rdata are 0.
- Request sampled in IDLE at cycle N. mem_req is high from N+1.
- mem_ack at cycle M ≥ N+1. Completion pulse at M+1 (RESP). IDLE at M+2, where the next request may be sampled.
- Minimum latency is 2 cycles (request to pulse). Maximum throughput is one access per 3 cycles.
- Simultaneous if_req and dmem_req: the data access goes first. The fetch is issued after the data access's RESP.
- Reset mid-transaction: mem_req drops on the reset edge and no completion pulse is produced. A late mem_ack is ignored.
- Request deasserted while busy: the transaction still completes. The completion pulse is still produced.

## Configuration
- MEM_ARB_MISALIGN_CHECK_EN defined:
  - HALF with addr[0]=1, or WORD with addr[1:0]≠0, is misaligned.
  - A misaligned access issues no memory transaction: IDLE→RESP directly.
  - RESP pulses dmem_done with dmem_err=1 and dmem_rdata=0.
- Not defined:
  - dmem_err is tied 0 and no alignment check is made.
  - HALF uses only addr[1] for lane selection; WORD ignores addr[1:0].

## Test plan
- Fetch: if_req=1, if_addr=0x104; mem_ack after 3 cycles with rdata=0x00500093 -> mem_addr=0x104, mem_be=4'hF. if_valid pulses with 0x00500093 exactly 1 cycle after the ack.
- Store byte: dmem_wr=1, BYTE, addr=0x203, wdata=0xAB -> mem_be=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x200. dmem_done one cycle after ack.
- Loads of mem_rdata=0x80F0_7F01:
  - LB at 0x202 -> 0xFFFFFFF0.
  - LBU at 0x202 -> 0x000000F0.
  - LH at 0x202 -> 0xFFFF80F0.
  - LHU at 0x200 -> 0x00007F01.
- Contention: if_req and dmem_req rise together -> data transaction first. The fetch follows; stall stays high until if_valid.
- Reset while D_BUSY, then mem_ack the next cycle -> no dmem_done, FSM in IDLE, mem_req=0.
- With MEM_ARB_MISALIGN_CHECK_EN: LW at 0x202 -> mem_req never asserts. dmem_done and dmem_err pulse 1 cycle after sampling, with dmem_rdata=0.
